// File: rtl/pwm_multi_shadowed.sv
// Multi-channel PWM with one shared counter, edge or center alignment, and shadowed period/duty/mode.
// Staged values are applied together at a period boundary, or at once while disabled.
module pwm_multi_shadowed #(
  parameter int NUM_CH         = 3,
  parameter int CNT_W          = 11,
  parameter int DEFAULT_PERIOD = 1200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [CNT_W-1:0]        period_in,
  input  logic [NUM_CH*CNT_W-1:0] duty_in,
  input  logic                    center_in,
  output logic                    load_pending,
  output logic                    period_start,
  output logic [NUM_CH-1:0]       pwm_out
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    dn_q, dn_d;
  logic [CNT_W-1:0]        per_act_q, per_act_d;
  logic [NUM_CH*CNT_W-1:0] duty_act_q, duty_act_d;
  logic                    ctr_act_q, ctr_act_d;
  logic [CNT_W-1:0]        per_stg_q, per_stg_d;
  logic [NUM_CH*CNT_W-1:0] duty_stg_q, duty_stg_d;
  logic                    ctr_stg_q, ctr_stg_d;
  logic                    pend_q, pend_d;
  logic                    ps_q, ps_d;
  logic [NUM_CH-1:0]       pwm_q, pwm_d;

  logic [CNT_W-1:0] per_m1;
  logic             at_top;
  logic             boundary;
  logic             apply;

  // Active period is never 0 (clamped on capture), so P-1 cannot wrap.
  assign per_m1   = per_act_q - ONE;
  assign at_top   = (cnt_q == per_m1);
  assign boundary = enable && (ctr_act_q ? (dn_q && (cnt_q == '0)) : at_top);
  assign apply    = pend_q && (boundary || !enable);

  always_comb begin
    cnt_d      = cnt_q;
    dn_d       = dn_q;
    per_act_d  = per_act_q;
    duty_act_d = duty_act_q;
    ctr_act_d  = ctr_act_q;
    per_stg_d  = per_stg_q;
    duty_stg_d = duty_stg_q;
    ctr_stg_d  = ctr_stg_q;
    pend_d     = pend_q;
    pwm_d      = '0;

    if (!enable || boundary) begin
      cnt_d = '0;
      dn_d  = 1'b0;
    end else if (!ctr_act_q) begin
      cnt_d = cnt_q + ONE;
    end else if (dn_q) begin
      cnt_d = cnt_q - ONE;
    end else if (at_top) begin
      // Top of the triangle is held for a second cycle while turning around.
      dn_d = 1'b1;
    end else begin
      cnt_d = cnt_q + ONE;
    end

    if (apply) begin
      per_act_d  = per_stg_q;
      duty_act_d = duty_stg_q;
      ctr_act_d  = ctr_stg_q;
      pend_d     = 1'b0;
    end

    // A load on a boundary cycle lands in staging after the old staging was consumed.
    if (load) begin
      per_stg_d  = (period_in == '0) ? ONE : period_in;
      duty_stg_d = duty_in;
      ctr_stg_d  = center_in;
      pend_d     = 1'b1;
    end

    ps_d = enable && (cnt_q == '0) && !dn_q;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = enable && (cnt_q < duty_act_q[i*CNT_W +: CNT_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      dn_q       <= 1'b0;
      per_act_q  <= DEF_P;
      duty_act_q <= '0;
      ctr_act_q  <= 1'b0;
      per_stg_q  <= '0;
      duty_stg_q <= '0;
      ctr_stg_q  <= 1'b0;
      pend_q     <= 1'b0;
      ps_q       <= 1'b0;
      pwm_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      dn_q       <= dn_d;
      per_act_q  <= per_act_d;
      duty_act_q <= duty_act_d;
      ctr_act_q  <= ctr_act_d;
      per_stg_q  <= per_stg_d;
      duty_stg_q <= duty_stg_d;
      ctr_stg_q  <= ctr_stg_d;
      pend_q     <= pend_d;
      ps_q       <= ps_d;
      pwm_q      <= pwm_d;
    end
  end

  assign load_pending = pend_q;
  assign period_start = ps_q;
  assign pwm_out      = pwm_q;

endmodule

// File: tb/tb_pwm_multi_shadowed.sv
// Bench for pwm_multi_shadowed: table of steady-state waveforms plus hand sequences for shadow timing.
module tb_pwm_multi_shadowed;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        center_in = 1'b0;
  logic [10:0] period_in = '0;
  logic [32:0] duty_in = '0;
  logic        load_pending;
  logic        period_start;
  logic [2:0]  pwm_out;

  always #5 clk = ~clk;

  pwm_multi_shadowed #(.NUM_CH(3), .CNT_W(11), .DEFAULT_PERIOD(1200)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load),
    .period_in(period_in), .duty_in(duty_in), .center_in(center_in),
    .load_pending(load_pending), .period_start(period_start), .pwm_out(pwm_out)
  );

  typedef struct {
    int         tgt;
    logic [2:0] pwm;
    logic       ps;
    logic       lp;
    logic [2:0] m;   // [0] pwm, [1] period_start, [2] load_pending
    string      name;
  } exp_t;

  typedef struct {
    logic [10:0] per;
    logic [10:0] d0, d1, d2;
    logic        c;
    int          len;
    int          h0, h1, h2;
    int          ncyc;
  } vec_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[5];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].tgt <= cyc) begin
      e = sb.pop_front();
      if (e.tgt != cyc) begin
        checks++; failures++;
        $display("FAIL %s stale expectation tgt=%0d now=%0d", e.name, e.tgt, cyc);
      end
      if (e.m[0]) begin
        checks++;
        if (pwm_out !== e.pwm) begin
          failures++;
          $display("FAIL %s cyc=%0d pwm_out=%b expected=%b", e.name, cyc, pwm_out, e.pwm);
        end
      end
      if (e.m[1]) begin
        checks++;
        if (period_start !== e.ps) begin
          failures++;
          $display("FAIL %s cyc=%0d period_start=%b expected=%b", e.name, cyc, period_start, e.ps);
        end
      end
      if (e.m[2]) begin
        checks++;
        if (load_pending !== e.lp) begin
          failures++;
          $display("FAIL %s cyc=%0d load_pending=%b expected=%b", e.name, cyc, load_pending, e.lp);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue what the outputs must show after that edge.
  task automatic step(input logic r, input logic en, input logic ld, input logic [2:0] m,
                      input logic [2:0] epwm, input logic eps, input logic elp, input string nm);
    exp_t e;
    rst = r; enable = en; load = ld;
    e.tgt = cyc + 1; e.pwm = epwm; e.ps = eps; e.lp = elp; e.m = m; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic pat(input int k, input int len, input int h, input logic c);
    int ph;
    ph = k % len;
    if (c) return (ph < h / 2) || (ph >= len - h / 2);
    return ph < h;
  endfunction

  task automatic setup(input logic [10:0] p, input logic [10:0] d0, input logic [10:0] d1,
                       input logic [10:0] d2, input logic c);
    step(1'b1, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, "reset");
    period_in = p; duty_in = {d2, d1, d0}; center_in = c;
    step(1'b0, 1'b0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b1, "load_idle");
    step(1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, "apply_idle");
  endtask

  initial begin
    logic [2:0] ep;
    int         dd;
    logic       lp;

    tbl[0] = '{per: 11'd10, d0: 11'd3, d1: 11'd0,  d2: 11'd10, c: 1'b0, len: 10, h0: 3, h1: 0,  h2: 10, ncyc: 25};
    tbl[1] = '{per: 11'd10, d0: 11'd3, d1: 11'd5,  d2: 11'd9,  c: 1'b1, len: 20, h0: 6, h1: 10, h2: 18, ncyc: 45};
    tbl[2] = '{per: 11'd0,  d0: 11'd1, d1: 11'd0,  d2: 11'd5,  c: 1'b0, len: 1,  h0: 1, h1: 0,  h2: 1,  ncyc: 4};
    tbl[3] = '{per: 11'd1,  d0: 11'd1, d1: 11'd0,  d2: 11'd2,  c: 1'b1, len: 2,  h0: 2, h1: 0,  h2: 2,  ncyc: 6};
    tbl[4] = '{per: 11'd7,  d0: 11'd7, d1: 11'd8,  d2: 11'd6,  c: 1'b0, len: 7,  h0: 7, h1: 7,  h2: 6,  ncyc: 14};

    @(posedge clk);
    #1;

    for (int t = 0; t < 5; t++) begin
      setup(tbl[t].per, tbl[t].d0, tbl[t].d1, tbl[t].d2, tbl[t].c);
      for (int k = 0; k < tbl[t].ncyc; k++) begin
        ep = {pat(k, tbl[t].len, tbl[t].h2, tbl[t].c),
              pat(k, tbl[t].len, tbl[t].h1, tbl[t].c),
              pat(k, tbl[t].len, tbl[t].h0, tbl[t].c)};
        step(1'b0, 1'b1, 1'b0, 3'b111, ep, (k % tbl[t].len) == 0, 1'b0, $sformatf("vec%0d_k%0d", t, k));
      end
      step(1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, $sformatf("vec%0d_disable", t));
    end

    // Mid-period load: current period finishes with the old duty.
    setup(11'd10, 11'd3, 11'd0, 11'd10, 1'b0);
    for (int k = 0; k < 25; k++) begin
      if (k == 4) duty_in = {11'd10, 11'd0, 11'd7};
      dd = (k < 10) ? 3 : 7;
      ep = {1'b1, 1'b0, (k % 10) < dd};
      step(1'b0, 1'b1, k == 4, 3'b111, ep, (k % 10) == 0, (k >= 4 && k <= 8), $sformatf("midload_k%0d", k));
    end

    // Loads on the boundary cycle, first with nothing pending, then with a set already staged.
    setup(11'd10, 11'd7, 11'd0, 11'd10, 1'b0);
    for (int k = 0; k < 50; k++) begin
      if (k == 9)  duty_in = {11'd10, 11'd0, 11'd2};
      if (k == 25) duty_in = {11'd10, 11'd0, 11'd5};
      if (k == 29) duty_in = {11'd10, 11'd0, 11'd1};
      dd = (k < 20) ? 7 : (k < 30) ? 2 : (k < 40) ? 5 : 1;
      lp = (k >= 9 && k <= 18) || (k >= 25 && k <= 38);
      ep = {1'b1, 1'b0, (k % 10) < dd};
      step(1'b0, 1'b1, (k == 9 || k == 25 || k == 29), 3'b111, ep, (k % 10) == 0, lp,
           $sformatf("bndload_k%0d", k));
    end

    // Reset mid-period with a pending load, then default period and zero duties.
    setup(11'd10, 11'd1, 11'd1, 11'd1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin period_in = 11'd5; duty_in = {11'd4, 11'd4, 11'd4}; end
      step(1'b0, 1'b1, k == 3, 3'b111, (k == 0) ? 3'b111 : 3'b000, k == 0, k >= 3, $sformatf("prerst_k%0d", k));
    end
    step(1'b1, 1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, "midrst");
    step(1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, "postrst_idle");
    for (int k = 0; k <= 1200; k++) begin
      step(1'b0, 1'b1, 1'b0, 3'b111, 3'b000, (k % 1200) == 0, 1'b0, $sformatf("default_k%0d", k));
    end
    enable = 1'b0;

    for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain %0d expectations left unchecked, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
